// File: rtl/ibex_simd_sat_stage_pkg.sv
// Shared types and decode helpers for the packed
// saturation / halving post-adder stage.
package ibex_simd_sat_stage_pkg;

  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_KADD8,
    ALU_KSUB8,
    ALU_UKADD8,
    ALU_UKSUB8,
    ALU_RADD8,
    ALU_RSUB8,
    ALU_URADD8,
    ALU_URSUB8,
    ALU_KADD16,
    ALU_KSUB16,
    ALU_UKADD16,
    ALU_UKSUB16,
    ALU_RADD16,
    ALU_RSUB16,
    ALU_URADD16,
    ALU_URSUB16
  } alu_op_e;

  typedef enum logic [1:0] {
    AW_32,
    AW_16,
    AW_8
  } aluwidth_e;

  typedef enum logic [2:0] {
    FIX_NONE,
    FIX_SAT_S,
    FIX_SAT_U,
    FIX_HALVE_S,
    FIX_HALVE_U
  } simd_fix_e;

  localparam logic [7:0]  SAT8_MAX_S  = 8'h7F;
  localparam logic [7:0]  SAT8_MIN_S  = 8'h80;
  localparam logic [15:0] SAT16_MAX_S = 16'h7FFF;
  localparam logic [15:0] SAT16_MIN_S = 16'h8000;

  function automatic simd_fix_e op_to_simd_fix(
    alu_op_e op
  );
    simd_fix_e f;
    unique case (op)
      ALU_KADD8, ALU_KSUB8,
      ALU_KADD16, ALU_KSUB16:
        f = FIX_SAT_S;
      ALU_UKADD8, ALU_UKSUB8,
      ALU_UKADD16, ALU_UKSUB16:
        f = FIX_SAT_U;
      ALU_RADD8, ALU_RSUB8,
      ALU_RADD16, ALU_RSUB16:
        f = FIX_HALVE_S;
      ALU_URADD8, ALU_URSUB8,
      ALU_URADD16, ALU_URSUB16:
        f = FIX_HALVE_U;
      default:
        f = FIX_NONE;
    endcase
    return f;
  endfunction

  function automatic aluwidth_e op_to_width(
    alu_op_e op
  );
    aluwidth_e w;
    unique case (op)
      ALU_KADD8, ALU_KSUB8,
      ALU_UKADD8, ALU_UKSUB8,
      ALU_RADD8, ALU_RSUB8,
      ALU_URADD8, ALU_URSUB8:
        w = AW_8;
      ALU_KADD16, ALU_KSUB16,
      ALU_UKADD16, ALU_UKSUB16,
      ALU_RADD16, ALU_RSUB16,
      ALU_URADD16, ALU_URSUB16:
        w = AW_16;
      default:
        w = AW_32;
    endcase
    return w;
  endfunction

  function automatic logic op_is_sub(
    alu_op_e op
  );
    logic s;
    unique case (op)
      ALU_SUB,
      ALU_KSUB8, ALU_UKSUB8,
      ALU_RSUB8, ALU_URSUB8,
      ALU_KSUB16, ALU_UKSUB16,
      ALU_RSUB16, ALU_URSUB16:
        s = 1'b1;
      default:
        s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ibex_simd_sat_stage_lane_fix.sv
// One packed lane: saturation or halving correction
// applied to a wrapped lane sum.
module ibex_simd_lane_fix
  import ibex_simd_sat_stage_pkg::*;
#(
  parameter int LaneW = 8
) (
  input  logic [LaneW-1:0] sum,
  input  logic             a_msb,
  input  logic             b_eff_msb,
  input  logic             carry,
  input  logic             sub,
  input  simd_fix_e        fix,
  output logic [LaneW-1:0] res,
  output logic             sat
);

  localparam logic [LaneW-1:0] MaxS =
    (LaneW == 8) ? LaneW'(SAT8_MAX_S)
                 : LaneW'(SAT16_MAX_S);
  localparam logic [LaneW-1:0] MinS =
    (LaneW == 8) ? LaneW'(SAT8_MIN_S)
                 : LaneW'(SAT16_MIN_S);

  logic sum_msb;
  logic ovf;
  logic s_sign;
  logic u_sign;

  assign sum_msb = sum[LaneW-1];
  assign ovf = (a_msb == b_eff_msb) &&
               (sum_msb != a_msb);
  assign s_sign = sum_msb ^ ovf;
  // bit above the lane for unsigned ops; set
  // means overflow on add, borrow on subtract
  assign u_sign = sub ? ~carry : carry;

  // clamp or halve depending on the lane mode
  always_comb begin
    res = sum;
    sat = 1'b0;
    unique case (fix)
      FIX_SAT_S: begin
        if (ovf) begin
          sat = 1'b1;
          res = a_msb ? MinS : MaxS;
        end
      end
      FIX_SAT_U: begin
        if (u_sign) begin
          sat = 1'b1;
          res = sub ? '0 : '1;
        end
      end
      FIX_HALVE_S:
        res = {s_sign, sum[LaneW-1:1]};
      FIX_HALVE_U:
        res = {u_sign, sum[LaneW-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ibex_simd_sat_stage.sv
// Registered packed-SIMD post-adder stage with
// per-lane saturation/halving and sticky OV flag.
module ibex_simd_sat_stage
  import ibex_simd_sat_stage_pkg::*;
#(
  parameter bit SatEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  alu_op_e     operator_i,
  input  logic [31:0] sum_i,
  input  logic [3:0]  lane_carry_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic [3:0]  lane_sat_o,
  input  logic        csr_we_i,
  input  logic        csr_wdata_i,
  output logic        ov_o
);

  simd_fix_e fix_raw;
  simd_fix_e fix;
  aluwidth_e width;
  logic      sub;

  logic [3:0][7:0]  r8;
  logic [3:0]       s8;
  logic [1:0][15:0] r16;
  logic [1:0]       s16;

  logic [31:0] res_d;
  logic [3:0]  sat_d;
  logic        accept;
  logic        ov_set;
  logic        unused_ok;

  assign fix_raw = op_to_simd_fix(operator_i);
  assign width   = op_to_width(operator_i);
  assign sub     = op_is_sub(operator_i);

  assign fix =
    (!SatEn && (fix_raw == FIX_SAT_S ||
                fix_raw == FIX_SAT_U))
      ? FIX_NONE : fix_raw;

  // only lane sign bits of the operands matter
  assign unused_ok = ^{op_a_i, op_b_i};

  for (genvar g = 0; g < 4; g++) begin : g_l8
    ibex_simd_lane_fix #(
      .LaneW (8)
    ) u_fix (
      .sum       (sum_i[8*g+:8]),
      .a_msb     (op_a_i[8*g+7]),
      .b_eff_msb (op_b_i[8*g+7] ^ sub),
      .carry     (lane_carry_i[g]),
      .sub       (sub),
      .fix       (fix),
      .res       (r8[g]),
      .sat       (s8[g])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : g_l16
    ibex_simd_lane_fix #(
      .LaneW (16)
    ) u_fix (
      .sum       (sum_i[16*g+:16]),
      .a_msb     (op_a_i[16*g+15]),
      .b_eff_msb (op_b_i[16*g+15] ^ sub),
      .carry     (lane_carry_i[2*g+1]),
      .sub       (sub),
      .fix       (fix),
      .res       (r16[g]),
      .sat       (s16[g])
    );
  end

  // pick lane bank by operation width
  always_comb begin
    res_d = sum_i;
    sat_d = '0;
    unique case (width)
      AW_8: begin
        res_d = r8;
        sat_d = s8;
      end
      AW_16: begin
        res_d = r16;
        sat_d = {s16[1], s16[1],
                 s16[0], s16[0]};
      end
      default: ;
    endcase
  end

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept = in_valid_i && in_ready_o &&
                  !flush_i;
  assign ov_set = out_valid_o && out_ready_i &&
                  !flush_i && |lane_sat_o;

  // output register, handshake and sticky OV
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      lane_sat_o  <= '0;
      ov_o        <= 1'b0;
    end else begin
      if (flush_i) begin
        out_valid_o <= 1'b0;
      end else if (in_ready_o) begin
        out_valid_o <= in_valid_i;
      end
      if (accept) begin
        result_o   <= res_d;
        lane_sat_o <= sat_d;
      end
      ov_o <= (csr_we_i ? csr_wdata_i : ov_o) |
              ov_set;
    end
  end

endmodule

// File: tb/tb_ibex_simd_sat_stage.sv
// Self-checking bench for ibex_simd_sat_stage:
// fixed vectors, corner sequences, random ops.
module tb_ibex_simd_sat_stage;
  import ibex_simd_sat_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  alu_op_e     operator_i;
  logic [31:0] sum_i;
  logic [3:0]  lane_carry_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [3:0]  lane_sat_o;
  logic        csr_we_i;
  logic        csr_wdata_i;
  logic        ov_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ibex_simd_sat_stage #(
    .SatEn (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .operator_i   (operator_i),
    .sum_i        (sum_i),
    .lane_carry_i (lane_carry_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .flush_i      (flush_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .result_o     (result_o),
    .lane_sat_o   (lane_sat_o),
    .csr_we_i     (csr_we_i),
    .csr_wdata_i  (csr_wdata_i),
    .ov_o         (ov_o)
  );

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  sat;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  s;
  } exp_t;

  vec_t tbl[7];
  exp_t q[$];

  alu_op_e ops[18] = '{
    ALU_ADD, ALU_SUB,
    ALU_KADD8, ALU_KSUB8, ALU_UKADD8, ALU_UKSUB8,
    ALU_RADD8, ALU_RSUB8, ALU_URADD8, ALU_URSUB8,
    ALU_KADD16, ALU_KSUB16, ALU_UKADD16,
    ALU_UKSUB16, ALU_RADD16, ALU_RSUB16,
    ALU_URADD16, ALU_URSUB16
  };

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 plain, 1 saturate, 2 halve
  function automatic void dec(
    input alu_op_e op, output int w,
    output bit sgn, output bit sub,
    output int kind);
    w = 32; sgn = 0; sub = 0; kind = 0;
    case (op)
      ALU_SUB:     begin sub = 1; end
      ALU_KADD8:   begin w = 8;  sgn = 1; kind = 1; end
      ALU_KSUB8:   begin w = 8;  sgn = 1; sub = 1; kind = 1; end
      ALU_UKADD8:  begin w = 8;  kind = 1; end
      ALU_UKSUB8:  begin w = 8;  sub = 1; kind = 1; end
      ALU_RADD8:   begin w = 8;  sgn = 1; kind = 2; end
      ALU_RSUB8:   begin w = 8;  sgn = 1; sub = 1; kind = 2; end
      ALU_URADD8:  begin w = 8;  kind = 2; end
      ALU_URSUB8:  begin w = 8;  sub = 1; kind = 2; end
      ALU_KADD16:  begin w = 16; sgn = 1; kind = 1; end
      ALU_KSUB16:  begin w = 16; sgn = 1; sub = 1; kind = 1; end
      ALU_UKADD16: begin w = 16; kind = 1; end
      ALU_UKSUB16: begin w = 16; sub = 1; kind = 1; end
      ALU_RADD16:  begin w = 16; sgn = 1; kind = 2; end
      ALU_RSUB16:  begin w = 16; sgn = 1; sub = 1; kind = 2; end
      ALU_URADD16: begin w = 16; kind = 2; end
      ALU_URSUB16: begin w = 16; sub = 1; kind = 2; end
      default: ;
    endcase
  endfunction

  function automatic longint lane_of(
    logic [31:0] v, int l, int w);
    return (longint'(v) >> (l * w)) &
           ((longint'(1) << w) - 1);
  endfunction

  // upstream packed adder: wrapped sums, carries
  function automatic void adder(
    input alu_op_e op, input logic [31:0] a,
    input logic [31:0] b,
    output logic [31:0] s,
    output logic [3:0] c);
    int w, kind;
    bit sgn, sub;
    longint x, y, v, m;
    logic [31:0] be;
    dec(op, w, sgn, sub, kind);
    s = '0;
    c = 4'($urandom);
    be = sub ? ~b : b;
    m = (longint'(1) << w) - 1;
    for (int l = 0; l < 32 / w; l++) begin
      x = lane_of(a, l, w);
      y = lane_of(be, l, w);
      v = x + y + (sub ? 1 : 0);
      s = s | 32'((v & m) << (l * w));
      c[(l * w + w) / 8 - 1] = 1'((v >> w) & 1);
    end
  endfunction

  // arithmetic reference on true lane values
  function automatic void ref_op(
    input alu_op_e op, input logic [31:0] a,
    input logic [31:0] b,
    output logic [31:0] r,
    output logic [3:0] s);
    int w, kind;
    bit sgn, sub, hit;
    longint x, y, v, m, lo, hi, full;
    dec(op, w, sgn, sub, kind);
    r = '0;
    s = '0;
    if (kind == 0) begin
      r = sub ? a - b : a + b;
      return;
    end
    full = longint'(1) << w;
    m = full - 1;
    lo = sgn ? -(full / 2) : 0;
    hi = sgn ? (full / 2) - 1 : full - 1;
    for (int l = 0; l < 32 / w; l++) begin
      x = lane_of(a, l, w);
      y = lane_of(b, l, w);
      if (sgn && x >= full / 2) x -= full;
      if (sgn && y >= full / 2) y -= full;
      v = sub ? x - y : x + y;
      hit = 0;
      if (kind == 1) begin
        if (v > hi) begin v = hi; hit = 1; end
        if (v < lo) begin v = lo; hit = 1; end
      end else begin
        v = v >>> 1;
      end
      r = r | 32'((v & m) << (l * w));
      if (hit)
        s = s | ((w == 8) ? 4'(1 << l)
                          : 4'(3 << (2 * l)));
    end
  endfunction

  task automatic drive(alu_op_e op,
                       logic [31:0] a,
                       logic [31:0] b);
    logic [31:0] s;
    logic [3:0]  c;
    adder(op, a, b, s, c);
    operator_i   = op;
    op_a_i       = a;
    op_b_i       = b;
    sum_i        = s;
    lane_carry_i = c;
  endtask

  task automatic clear_ov();
    in_valid_i  = 0;
    csr_we_i    = 1;
    csr_wdata_i = 0;
    tick();
    csr_we_i = 0;
  endtask

  initial begin
    logic [31:0] a, b;
    alu_op_e     op;
    exp_t        e;
    logic        acc, ret, rsat, ovm;

    tbl[0] = '{ALU_KADD8, 32'h7F8001FF,
               32'h01FF0101, 32'h7F800200, 4'b1100};
    tbl[1] = '{ALU_UKSUB16, 32'h0005FFFF,
               32'h00060001, 32'h0000FFFE, 4'b1100};
    tbl[2] = '{ALU_RADD8, 32'h7F7F8080,
               32'h01018080, 32'h40408080, 4'b0000};
    tbl[3] = '{ALU_URSUB8, 32'h00000003,
               32'h01000001, 32'hFF000001, 4'b0000};
    tbl[4] = '{ALU_KSUB16, 32'h80000001,
               32'h00010002, 32'h8000FFFF, 4'b1100};
    tbl[5] = '{ALU_ADD, 32'h7FFFFFFF,
               32'h00000001, 32'h80000000, 4'b0000};
    tbl[6] = '{ALU_UKADD8, 32'hFF0180FF,
               32'h01FE7F00, 32'hFFFFFFFF, 4'b1000};

    rst_i = 1; in_valid_i = 0; flush_i = 0;
    out_ready_i = 1; csr_we_i = 0;
    csr_wdata_i = 0;
    drive(ALU_ADD, 32'h0, 32'h0);
    tick();
    tick();
    rst_i = 0;
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_result", result_o, 0);
    chk("rst_sat", 32'(lane_sat_o), 0);
    chk("rst_ov", 32'(ov_o), 0);
    chk("rst_ready", 32'(in_ready_o), 1);

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b);
      in_valid_i = 1; out_ready_i = 1;
      csr_we_i = 1; csr_wdata_i = 0;
      tick();
      in_valid_i = 0; csr_we_i = 0;
      chk($sformatf("vec%0d_valid", i),
          32'(out_valid_o), 1);
      chk($sformatf("vec%0d_result", i),
          result_o, tbl[i].res);
      chk($sformatf("vec%0d_sat", i),
          32'(lane_sat_o), 32'(tbl[i].sat));
      tick();
      chk($sformatf("vec%0d_ov", i),
          32'(ov_o), 32'(|tbl[i].sat));
    end

    // backpressure: op1 held, op2 waiting
    drive(tbl[0].op, tbl[0].a, tbl[0].b);
    in_valid_i = 1; out_ready_i = 1;
    tick();
    drive(tbl[2].op, tbl[2].a, tbl[2].b);
    out_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d_ready", i),
          32'(in_ready_o), 0);
      tick();
      chk($sformatf("bp%0d_hold", i),
          result_o, tbl[0].res);
      chk($sformatf("bp%0d_valid", i),
          32'(out_valid_o), 1);
    end
    out_ready_i = 1;
    #1;
    chk("bp_ready_rise", 32'(in_ready_o), 1);
    tick();
    in_valid_i = 0;
    chk("bp_op2_result", result_o, tbl[2].res);
    chk("bp_op2_valid", 32'(out_valid_o), 1);
    tick();

    // flush a held saturating op
    clear_ov();
    drive(tbl[0].op, tbl[0].a, tbl[0].b);
    in_valid_i = 1; out_ready_i = 0;
    tick();
    drive(tbl[6].op, tbl[6].a, tbl[6].b);
    flush_i = 1; out_ready_i = 1;
    #1;
    chk("fl_ready", 32'(in_ready_o), 1);
    tick();
    flush_i = 0; in_valid_i = 0;
    chk("fl_valid", 32'(out_valid_o), 0);
    chk("fl_ov", 32'(ov_o), 0);
    tick();
    chk("fl_no_accept", 32'(out_valid_o), 0);
    chk("fl_ov_late", 32'(ov_o), 0);

    // CSR write of 0 races a saturating retire
    drive(tbl[0].op, tbl[0].a, tbl[0].b);
    in_valid_i = 1; out_ready_i = 1;
    tick();
    in_valid_i = 0;
    csr_we_i = 1; csr_wdata_i = 0;
    tick();
    csr_we_i = 0;
    chk("csr_race_ov", 32'(ov_o), 1);
    clear_ov();
    chk("csr_clear_ov", 32'(ov_o), 0);
    csr_we_i = 1; csr_wdata_i = 1;
    tick();
    csr_we_i = 0;
    chk("csr_set_ov", 32'(ov_o), 1);
    clear_ov();

    // randomized traffic against the model
    ovm = 0;
    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 17)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        a = 32'h7F7F7F7F ^ (a & 32'h80808080);
        b = b & 32'h81818181;
      end
      drive(op, a, b);
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      csr_we_i    = ($urandom_range(0, 15) == 0);
      csr_wdata_i = 1'($urandom_range(0, 1));
      #1;
      acc = in_valid_i && in_ready_o;
      ret = out_valid_o && out_ready_i;
      rsat = 0;
      if (ret) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL rnd_spurious: valid %0b with none pending",
                   out_valid_o);
        end else begin
          e = q.pop_front();
          chk($sformatf("rnd%0d_result", i),
              result_o, e.r);
          chk($sformatf("rnd%0d_sat", i),
              32'(lane_sat_o), 32'(e.s));
          rsat = |e.s;
        end
      end
      ovm = (csr_we_i ? csr_wdata_i : ovm) | rsat;
      if (acc) begin
        ref_op(op, a, b, e.r, e.s);
        q.push_back(e);
      end
      tick();
      chk($sformatf("rnd%0d_valid", i),
          32'(out_valid_o), 32'(q.size() != 0));
      chk($sformatf("rnd%0d_ov", i),
          32'(ov_o), 32'(ovm));
    end
    in_valid_i = 0; out_ready_i = 1;
    csr_we_i = 0;
    tick();
    tick();

    // reset while a saturating op is stalled
    clear_ov();
    drive(tbl[0].op, tbl[0].a, tbl[0].b);
    in_valid_i = 1; out_ready_i = 1;
    tick();
    in_valid_i = 0; out_ready_i = 0;
    tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    chk("mrst_valid", 32'(out_valid_o), 0);
    chk("mrst_result", result_o, 0);
    chk("mrst_sat", 32'(lane_sat_o), 0);
    chk("mrst_ov", 32'(ov_o), 0);
    out_ready_i = 1;
    tick();
    chk("mrst_ov_after", 32'(ov_o), 0);

    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ibex_simd_sat_stage.md
Name: ibex_simd_sat_stage

Overview:
- Registered post-processing stage directly downstream of the packed P-extension adder (ibex_adder).
- Takes the wrapped per-lane sums, lane carries and operand sign bits. For saturating ops (K*/UK*) it applies per-lane saturation; for halving ops (R*/UR*) it applies a per-lane halving correction.
- Presents the final 32-bit packed result through a valid/ready pipeline register.
- Maintains the sticky overflow flag (vxsat/OV) for CSR access.

Parameters:
- SatEn, 1: 0 = K*/UK* ops pass wrapped results, lane_sat_o is always 0, and ov_o is never set.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  operation valid
- in_ready_o  out  1  stage can accept
- operator_i  in  alu_op_e  op of the incoming operation
- sum_i  in  32  wrapped lane sums (adder_result_ext[32:1])
- lane_carry_i  in  4  carry-out of byte lanes 0..3 (a + ~b + 1 carry for subtracts)
- op_a_i  in  32  operand a
- op_b_i  in  32  operand b (un-negated)
- flush_i  in  1  kill held and incoming operation
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts
- result_o  out  32  final packed result
- lane_sat_o  out  4  per-byte saturation mask of the held result
- csr_we_i  in  1  write OV flag
- csr_wdata_i  in  1  value to write
- ov_o  out  1  sticky OV flag

Behaviour:
- Reset (rst_i at posedge): out_valid_o=0, result_o=0, lane_sat_o=0, ov_o=0. in_ready_o=1 in the cycle after reset.
- Latency is 1 cycle. An operation accepted on in_valid_i && in_ready_o is presented on out_valid_o at the next edge.
- in_ready_o = !out_valid_o || out_ready_i. Back-to-back throughput is 1 op per cycle. While stalled, result_o and lane_sat_o hold stable.
- Lane width comes from operator_i: *8 ops use 4 × 8-bit lanes, *16 ops use 2 × 16-bit lanes, all other ops use 32-bit passthrough with no sat and no halving.
- Effective operand for subtracts: b_eff = ~b.
- Signed lane overflow: ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- True 9/17-bit sign:
  - signed ops: sum_msb ^ ovf
  - unsigned add: lane carry
  - unsigned sub: ~lane carry
- KADD/KSUB: on ovf, result = 0x7F.. if a_msb==0, else 0x80...
- UKADD: on carry, result = all-ones.
- UKSUB: on no-carry, result = 0.
- Saturated lanes set their lane_sat_o bits; a 16-bit lane sets both of its byte bits.
- RADD/RSUB/URADD/URSUB: result = {true sign, sum[msb:1]} per lane. Truncating, no rounding. ov_o is never affected.
- OV update: ov_d = (csr_we_i ? csr_wdata_i : ov_q) | set. set = out_valid_o && out_ready_i && !flush_i && |lane_sat_o.
  - Simultaneous CSR write of 0 and set results in 1.
- flush_i: at the next edge out_valid_o=0 and no input is accepted that cycle. in_ready_o stays asserted so upstream retires the op. A flushed op never sets OV.
- Reset mid-operation drops the held op without setting OV.
- Non-P ops pass sum_i unchanged with lane_sat_o=0.

Decomposition:
- ibex_pkg: reuse aluwidth_e. Add enum simd_fix_e {FIX_NONE, FIX_SAT_S, FIX_SAT_U, FIX_HALVE_S, FIX_HALVE_U} and a decode function op_to_simd_fix(alu_op_e). Constants SAT8_MAX_S=8'h7F and SAT8_MIN_S=8'h80, plus 16-bit equivalents.
- Sub-module ibex_simd_lane_fix (combinational, parameter LaneW=8/16): inputs sum, a_msb, b_eff_msb, carry, fix mode; outputs lane result and sat bit.
  - Instantiate 4×8 and 2×16; select per width.

Test Plan:
1. KADD8, a=0x7F8001FF, b=0x01FF0101 → result_o=0x7F800200, lane_sat_o=4'b1100; ov_o=1 the cycle after the handshake.
2. UKSUB16, a=0x0005FFFF, b=0x00060001 → result_o=0x0000FFFE, lane_sat_o=4'b1100, ov_o=1.
3. RADD8, a=0x7F7F8080, b=0x01018080 → result_o=0x40408080, lane_sat_o=0, ov_o unchanged (0).
4. URSUB8, a=0x00000003, b=0x01000001 → result_o=0xFF000001.
5. Backpressure: out_ready_i low for 3 cycles with op1 held and op2 offered. in_ready_o stays 0 and result_o stays stable. When out_ready_i rises, op1 completes and op2 is accepted the same cycle; op2 appears at the next edge.
6. Flush and CSR:
   - flush_i while a saturating KADD8 is held → out_valid_o=0, ov_o stays 0.
   - csr_we_i=1 with wdata=0 in the same cycle as a saturating handshake → ov_o=1.
   - rst_i pulse mid-stall → all outputs 0.
